// File: rtl/crc_byte_serializer.sv
// Byte-to-bit serializer feeding the serial CRC-8 block; one bit per clock, 1-cycle GAP with FRAME_DONE per frame.
// Optional SER_MSB_FIRST_EN sends each word MSB first (default LSB first); timing is identical in both builds.
module crc_byte_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_VALID,
  input  logic             IN_LAST,
  output logic             IN_READY,
  output logic             SER_DATA,
  output logic             SER_ACTIVE,
  output logic             FRAME_DONE
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             sh_last_q, sh_last_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_last_q, hold_last_d;
  logic             hold_full_q, hold_full_d;
  logic             ready_q, ready_d;
  logic             ser_data_q, ser_data_d;
  logic             ser_active_q, ser_active_d;
  logic             frame_done_q, frame_done_d;

  logic             accept;
  logic             last_bit;
  logic             load_pt;
  logic [CW-1:0]    bit_idx;

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    sh_last_d   = sh_last_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_last_d = hold_last_q;
    hold_full_d = hold_full_q;

    accept   = IN_VALID && ready_q;
    last_bit = (state_q == SHIFT) && (cnt_q == CNT_MAX);
    load_pt  = (state_q == IDLE) || (state_q == GAP) || (last_bit && !sh_last_q);

    if (load_pt) begin
      cnt_d = '0;
      // ready_q mirrors !hold_full_q, so a full hold and a new accept never coincide here.
      if (hold_full_q) begin
        sh_d        = hold_q;
        sh_last_d   = hold_last_q;
        hold_full_d = 1'b0;
        state_d     = SHIFT;
      end else if (accept) begin
        sh_d      = IN_DATA;
        sh_last_d = IN_LAST;
        state_d   = SHIFT;
      end else begin
        state_d = IDLE;
      end
    end else begin
      if (last_bit) begin
        state_d = GAP;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      if (accept) begin
        hold_d      = IN_DATA;
        hold_last_d = IN_LAST;
        hold_full_d = 1'b1;
      end
    end

`ifdef SER_MSB_FIRST_EN
    bit_idx = CNT_MAX - cnt_d;
`else
    bit_idx = cnt_d;
`endif

    // Outputs are precomputed from next-state values so they appear registered with no extra latency.
    ready_d      = !hold_full_d;
    ser_active_d = (state_d == SHIFT);
    ser_data_d   = (state_d == SHIFT) ? sh_d[bit_idx] : 1'b0;
    frame_done_d = (state_d == GAP);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      sh_q         <= '0;
      sh_last_q    <= 1'b0;
      cnt_q        <= '0;
      hold_q       <= '0;
      hold_last_q  <= 1'b0;
      hold_full_q  <= 1'b0;
      ready_q      <= 1'b1;
      ser_data_q   <= 1'b0;
      ser_active_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      sh_last_q    <= sh_last_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      hold_last_q  <= hold_last_d;
      hold_full_q  <= hold_full_d;
      ready_q      <= ready_d;
      ser_data_q   <= ser_data_d;
      ser_active_q <= ser_active_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign IN_READY   = ready_q;
  assign SER_DATA   = ser_data_q;
  assign SER_ACTIVE = ser_active_q;
  assign FRAME_DONE = frame_done_q;

endmodule

// File: doc/crc_byte_serializer.md
# crc_byte_serializer

Upstream feeder for the serial CRC-8 block. It accepts bytes over a valid/ready handshake and shifts them out one bit per clock on a DATA/ACTIVE pair that connects directly to the CRC block's serial inputs. It keeps ACTIVE continuous across back-to-back bytes of one frame and marks each frame end with a one-cycle FRAME_DONE pulse, aligned to the cycle in which the CRC register holds the final frame CRC.

## Interface
- WIDTH, 8: bits per input word; the shift counter is $clog2(WIDTH) bits wide.
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- IN_DATA  in  WIDTH  word to serialize.
- IN_VALID  in  1  IN_DATA/IN_LAST are valid.
- IN_LAST  in  1  this word is the last of a frame.
- IN_READY  out  1  the block can accept a word; equals !hold_full (register-driven, no combinational path from IN_VALID).
- SER_DATA  out  1  serial bit; drives the CRC block's DATA.
- SER_ACTIVE  out  1  SER_DATA is valid this cycle; drives the CRC block's ACTIVE.
- FRAME_DONE  out  1  one-cycle pulse after the last bit of a LAST word.

## Operation
- Storage:
  - shift register `sh` with its last flag and a bit counter `cnt` (0..WIDTH-1);
  - one holding register `hold` with its last flag and `hold_full`.
- States:
  - IDLE: `sh` empty.
  - SHIFT: bit `cnt` of the current word is presented.
  - GAP: one idle cycle after a LAST word.
- Handshake: a word is accepted on a rising edge where IN_VALID && IN_READY. Data is never dropped or duplicated.
- Load source for `sh`, evaluated at a "load point" (state IDLE, or SHIFT with cnt==WIDTH-1 and the current word not LAST):
  - `hold`, if hold_full; hold_full clears on the same edge;
  - otherwise the accepted input word, if any; the next state is SHIFT with cnt=0;
  - otherwise the next state is IDLE.
- An accepted word that is not consumed at a load point goes into `hold` and sets hold_full.
- The next state is SHIFT only when a word is loaded into `sh` at a load point.
- SHIFT with cnt==WIDTH-1 and the current word LAST: next state is GAP. GAP is never skipped, even when hold_full.
- GAP:
  - SER_ACTIVE=0 and FRAME_DONE=1.
  - Input acceptance into `hold` continues normally.
  - The next edge is a load point.
- Bit order: LSB first (bit 0 in the first SHIFT cycle), which matches the CRC block's right-shifting LFSR.
- SER_DATA=0 whenever SER_ACTIVE=0.
- All outputs are registered.

## Timing
- Reset (asynchronous, immediate):
  - SER_DATA=0, SER_ACTIVE=0, FRAME_DONE=0;
  - hold_full=0, so IN_READY=1;
  - state IDLE, cnt=0.
- Reset mid-operation discards `sh` and `hold` with no FRAME_DONE. The CRC block shares RST, so both restart together.
- Latency: a word accepted at edge k while IDLE presents bit 0 in cycle k+1. Its last bit is in cycle k+WIDTH.
- Throughput: one bit per cycle. Consecutive non-LAST words produce an unbroken SER_ACTIVE run with zero bubbles when the next word is in `hold` or arrives by the load-point edge.
- IN_READY falls the cycle after `hold` fills. It rises the cycle after `hold` moves into `sh`.
- Accept and load on the same edge:
  - hold_full=0: the input goes straight into `sh`.
  - hold_full=1: IN_READY=0, so no accept happens.
- FRAME_DONE is high exactly in the GAP cycle. The CRC block's CRC output holds the frame result in that cycle.

## Configuration
- SER_MSB_FIRST_EN defined: each word is sent MSB first (bit WIDTH-1 first, bit 0 last).
- SER_MSB_FIRST_EN undefined (default): LSB first.
- Latency, handshake and FRAME_DONE timing are identical in both builds.

## Test plan
- Reset: assert RST low mid-stream -> SER_ACTIVE=0, SER_DATA=0, FRAME_DONE=0 and IN_READY=1 immediately. After release there is no output until a new accept.
- Single word 0xA5, LAST=1, accepted at edge 0:
  - cycles 1–8: SER_ACTIVE=1, SER_DATA=1,0,1,0,0,1,0,1;
  - cycle 9: SER_ACTIVE=0, FRAME_DONE=1;
  - cycle 10: FRAME_DONE=0.
- Back-to-back 0x01 then 0x80 (LAST), IN_VALID held:
  - 0x01 accepted at edge 0 into `sh`; 0x80 accepted at edge 1 into `hold`;
  - IN_READY=0 in cycles 2–8 and 1 from cycle 9;
  - SER_ACTIVE=1 continuously in cycles 1–16;
  - FRAME_DONE=1 in cycle 17.
- Frame boundary with `hold` full: 0x0F (LAST) then 0xF0 (LAST) ready -> one GAP cycle with FRAME_DONE=1 between the two 8-bit bursts, then the second FRAME_DONE.
- Reset after 3 bits of 0xFF with `hold` full -> no further SER_ACTIVE, no FRAME_DONE, IN_READY=1.
- SER_MSB_FIRST_EN build, 0x01 LAST -> SER_DATA=0,0,0,0,0,0,0,1. The default build gives 1,0,0,0,0,0,0,0.
